// File: rtl/alu_mul_seq_if.sv
// alu_mul_seq bundle: request operands, alu_shift
// operand/result path and product/status outputs.
interface alu_mul_seq_if;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] sh_A;
  logic [3:0] sh_B;
  logic [7:0] sh_Y;
  logic [7:0] P;
  logic       busy;
  logic       done;

  modport master (
    output start, A, B, sh_Y,
    input  sh_A, sh_B, P, busy, done
  );

  modport slave (
    input  start, A, B, sh_Y,
    output sh_A, sh_B, P, busy, done
  );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 4x4 unsigned shift-and-add multiplier
// driving an external combinational alu_shift stage.
module alu_mul_seq #(
  parameter bit EARLY_EXIT = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  alu_mul_seq_if.slave m
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] p_q, p_d;

  logic [7:0] sum;
  logic [2:0] nxt_bit;
  logic [3:0] b_rest;
  logic       last;

  // Partial sum and exit test for the bit under work.
  always_comb begin
    sum     = b_q[idx_q] ? acc_q + m.sh_Y : acc_q;
    nxt_bit = {1'b0, idx_q} + 3'd1;
    b_rest  = b_q >> nxt_bit;
    last    = (idx_q == 2'd3) ||
              (EARLY_EXIT && (b_rest == 4'd0));
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    p_d     = p_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (m.start) begin
          a_d     = m.A;
          b_d     = m.B;
          idx_d   = 2'd0;
          acc_d   = 8'd0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = sum;
        if (last) begin
          p_d     = sum;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      idx_q   <= 2'd0;
      acc_q   <= 8'd0;
      p_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
    end
  end

  assign m.sh_A = a_q;
  assign m.sh_B = {2'b00, idx_q};
  assign m.P    = p_q;
  assign m.busy = (state_q == RUN);
  assign m.done = (state_q == DONE);

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Sequential 4x4 unsigned shift-and-add multiplier that sits around the combinational `alu_shift` stage. It drives `alu_shift`'s operand inputs with the latched multiplicand and a bit index, consumes the 8-bit shifted value the stage returns, and accumulates it into an 8-bit product. It computes one multiplier bit per clock and reports completion with a one-cycle `done` pulse.

## Interface
- `EARLY_EXIT`, default 0: when 1, finish as soon as all remaining multiplier bits are zero; when 0, always run 4 iterations.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  request a multiply; sampled only in IDLE or DONE.
- `A`  in  4  multiplicand, unsigned; captured on an accepted `start`.
- `B`  in  4  multiplier, unsigned; captured on an accepted `start`.
- `sh_A`  out  4  to `alu_shift` A; equals the latched multiplicand `a_reg`.
- `sh_B`  out  4  to `alu_shift` B; equals `{2'b00, idx}`.
- `sh_Y`  in  8  from `alu_shift` Y; combinational, valid in the same cycle.
- `P`  out  8  product register; holds its value until the next completion.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when `P` updates.

## Operation
- Internal state:
  - `a_reg[3:0]`, `b_reg[3:0]`: latched operands.
  - `idx[1:0]`: current multiplier bit index.
  - `acc[7:0]`: running sum.
  - FSM with states IDLE, RUN, DONE.
- IDLE:
  - `start=1` latches A and B, clears `acc` and `idx`, and moves to RUN.
  - Otherwise the block stays in IDLE.
- RUN, once per cycle:
  - If `b_reg[idx]=1`, `acc <= acc + sh_Y`. Otherwise `acc` holds.
  - Addition is 8-bit modulo. Overflow cannot occur, because the maximum product is 15*15 = 225.
- RUN exit condition: `idx==3`, or (`EARLY_EXIT==1` and `b_reg >> (idx+1) == 0`).
  - On exit: `P <=` the final sum (including this cycle's addend), `done <= 1`, and the FSM moves to DONE.
  - Otherwise: `idx <= idx+1`.
- DONE (one cycle):
  - `done` is 1 and `busy` is 0.
  - `start=1` behaves as in IDLE (back-to-back operation).
  - Otherwise the FSM returns to IDLE.
- `start` is ignored in RUN. The latched operands are not disturbed by changes on A or B.
- `sh_A` and `sh_B` are driven from registers in every state. In IDLE and DONE they show the last latched `a_reg` and `idx`.
- Reset (`rst_n=0` at a rising edge), including in the middle of an operation:
  - The FSM goes to IDLE.
  - `P`, `acc`, `a_reg`, `b_reg` and `idx` are cleared to 0.
  - `busy=0`, `done=0`, `sh_A=0`, `sh_B=0`.
  - Any in-flight result is discarded and no `done` is produced.

## Timing
- Edge numbering: E0 is the edge that accepts `start`; E1..E4 are the following edges.
- `busy` rises after E0.
- With `EARLY_EXIT=0`: RUN spans E0..E4. `P` and `done` update at E4, so `done` is visible 4 cycles after `start`. `busy` is high for exactly 4 cycles.
- With `EARLY_EXIT=1`, latency is (index of the highest set bit of B) + 1, with a minimum of 1. For example, B=0 or B=1 gives `done` after E1.
- `done` falls at the next edge, unless that edge starts a new operation, in which case `done` still falls and `busy` rises.
- Throughput: one result every 5 cycles at `EARLY_EXIT=0`, with `start` held high.
- `P` changes only on the `done` edge or on reset.

## Test plan
- **Basic multiply, `EARLY_EXIT=0`:** A=13, B=11, pulse `start`.
  - Required response: `busy` high for 4 cycles, then `done` for 1 cycle with P=143.
  - The monitor also checks that `sh_B` sequences 0,1,2,3.
- **Maximum and zero operands:** run A=15,B=15, then A=0,B=9, then A=9,B=0.
  - Required response: P=225, then 0, then 0. Each result takes 4 cycles at `EARLY_EXIT=0`.
- **Early exit, `EARLY_EXIT=1`:**
  - A=7, B=0: `done` after 1 cycle, P=0.
  - A=7, B=2: `done` after 2 cycles, P=14.
  - A=7, B=8: `done` after 4 cycles, P=56.
- **Busy protection:** start A=5, B=3. At E2, drive `start=1` with A=15, B=15.
  - Required response: the second `start` is ignored and P=15.
  - Changing A and B during RUN has no effect on the result.
- **Back-to-back operation:** hold `start=1`, with A=3,B=4 and then A=6,B=6 presented at the DONE cycle.
  - Required response: P=12 at the first `done`, then P=36 exactly 5 cycles later.
- **Reset mid-operation:** start A=9, B=9. Assert `rst_n=0` at E2 for one cycle.
  - Required response: all outputs 0 and no `done` pulse.
  - A following A=2, B=3 produces P=6.
